// File: rtl/token_sync_receiver.sv
// Clocked receiver for the four-phase bundled-data token channel: synchronises the
// request, captures tokens into a small FIFO and offers them on a valid/ready port.
module token_sync_receiver #(
  parameter int              WIDTH      = 8,
  parameter int              DEPTH      = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter bit              CHECK_INIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_req,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ack,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [15:0]                token_count,
  output logic                       first_token_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACKED} state_t;

  state_t            state, state_next;
  logic              req_m, req_s;
  logic              ack_next;
  logic              push, pop, full;
  logic              first_armed;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  // in_data is only trusted once req_s is high, which the bundling constraint guarantees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
    end else begin
      req_m <= in_req;
      req_s <= req_m;
    end
  end

  assign full      = (fifo_count == CW'(DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    state_next = state;
    ack_next   = in_ack;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && !full) begin
          push       = 1'b1;
          ack_next   = 1'b1;
          state_next = ACKED;
        end
      end
      ACKED: begin
        if (!req_s) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      in_ack <= 1'b0;
    end else begin
      state  <= state_next;
      in_ack <= ack_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Only the first push after reset is compared against the ring's initial token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token_count     <= '0;
      first_armed     <= 1'b1;
      first_token_err <= 1'b0;
    end else if (push) begin
      token_count <= token_count + 16'd1;
      first_armed <= 1'b0;
      if (CHECK_INIT && first_armed && (in_data != INIT_VALUE))
        first_token_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_token_sync_receiver.sv
// Scoreboard bench for token_sync_receiver: a sender task drives four-phase handshakes,
// a monitor pops expected tokens from a queue whenever the consumer accepts one.
module tb_token_sync_receiver;

  localparam int              WIDTH      = 8;
  localparam int              DEPTH      = 4;
  localparam logic [WIDTH-1:0] INIT_VALUE = 8'h00;
  localparam bit              CHECK_INIT = 1'b1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_req = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       fifo_count;
  logic [15:0]      token_count;
  logic             first_token_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         accepted = 0;
  bit         first_seen = 1'b0;
  bit         exp_err = 1'b0;
  int         ready_mode = 0;
  int         max_count = 0;

  token_sync_receiver #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_VALUE(INIT_VALUE), .CHECK_INIT(CHECK_INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_count(fifo_count), .token_count(token_count), .first_token_err(first_token_err)
  );

  always #5 clk = ~clk;

  // Consumer: 0 = stalled, 1 = always ready, 2 = random ready.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pop", 32'(out_data), 32'hDEAD);
        end else begin
          checkOutput("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic doReset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_req = 1'b0;
    exp_q.delete();
    accepted   = 0;
    first_seen = 1'b0;
    exp_err    = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic noteToken(input logic [7:0] data);
    exp_q.push_back(data);
    if (!first_seen) begin
      first_seen = 1'b1;
      exp_err    = CHECK_INIT && (data != INIT_VALUE);
    end
  endtask

  task automatic waitAck(input logic level, input int max_edges, output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    for (int i = 0; i < max_edges; i++) begin
      @(posedge clk);
      #2;
      edges++;
      if (in_ack === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic raiseReq(input logic [7:0] data);
    @(posedge clk);
    #3;
    in_data = data;
    in_req  = 1'b1;
    noteToken(data);
  endtask

  task automatic finishHandshake(input int max_edges, output int rise_edges);
    int e;
    bit ok;
    waitAck(1'b1, max_edges, rise_edges, ok);
    if (!ok) checkOutput("ack_rise_timeout", 32'(in_ack), 32'h1);
    else accepted++;
    #1 in_req = 1'b0;
    waitAck(1'b0, 20, e, ok);
    if (!ok) checkOutput("ack_fall_timeout", 32'(in_ack), 32'h0);
    in_data = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [7:0] data, output int rise_edges);
    raiseReq(data);
    finishHandshake(200, rise_edges);
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int i = 0; i < 50 && out_valid; i++) @(posedge clk);
    @(negedge clk);
    checkOutput("drained_queue", 32'(exp_q.size()), 32'h0);
    checkOutput("drained_valid", 32'(out_valid), 32'h0);
  endtask

  initial begin
    int lat;
    bit ok;

    // Reset state and a single 0x00 token.
    #1;
    checkOutput("reset_ack", 32'(in_ack), 32'h0);
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_fifo_count", 32'(fifo_count), 32'h0);
    checkOutput("reset_token_count", 32'(token_count), 32'h0);
    checkOutput("reset_err", 32'(first_token_err), 32'h0);
    doReset();
    ready_mode = 0;
    applyStimulus(8'h00, lat);
    checkOutput("ack_latency", 32'(lat), 32'd3);
    checkOutput("single_valid", 32'(out_valid), 32'h1);
    checkOutput("single_data", 32'(out_data), 32'h00);
    checkOutput("single_token_count", 32'(token_count), 32'(accepted));
    checkOutput("single_err", 32'(first_token_err), 32'(exp_err));
    drain();

    // Wrong first token leaves a sticky error.
    doReset();
    ready_mode = 1;
    applyStimulus(8'h5A, lat);
    applyStimulus(8'h00, lat);
    applyStimulus(8'h01, lat);
    checkOutput("sticky_err", 32'(first_token_err), 32'(exp_err));
    checkOutput("sticky_token_count", 32'(token_count), 32'd3);
    drain();

    // Full FIFO backpressure and the pop-then-push ordering.
    doReset();
    ready_mode = 0;
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h10 + i), lat);
    checkOutput("full_count", 32'(fifo_count), 32'd4);
    raiseReq(8'h14);
    repeat (6) @(posedge clk);
    #2 checkOutput("stall_ack", 32'(in_ack), 32'h0);
    ready_mode = 1;
    @(posedge clk);
    #2 ready_mode = 0;
    @(posedge clk);
    #2;
    checkOutput("pop_edge_ack", 32'(in_ack), 32'h0);
    checkOutput("pop_edge_count", 32'(fifo_count), 32'd3);
    @(posedge clk);
    #2;
    checkOutput("push_after_pop_ack", 32'(in_ack), 32'h1);
    checkOutput("push_after_pop_count", 32'(fifo_count), 32'd4);
    finishHandshake(5, lat);
    checkOutput("full_token_count", 32'(token_count), 32'd5);
    drain();

    // Continuous stream through an always-ready consumer.
    doReset();
    ready_mode = 1;
    max_count  = 0;
    for (int i = 1; i <= 10; i++) applyStimulus(8'(i), lat);
    drain();
    checkOutput("stream_max_count", 32'(max_count <= 2), 32'h1);
    checkOutput("stream_token_count", 32'(token_count), 32'd10);

    // Reset in the middle of a handshake.
    doReset();
    ready_mode = 0;
    raiseReq(8'h33);
    waitAck(1'b1, 20, lat, ok);
    checkOutput("pre_reset_ack", 32'(in_ack), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_ack", 32'(in_ack), 32'h0);
    checkOutput("mid_reset_count", 32'(fifo_count), 32'h0);
    exp_q.delete();
    accepted   = 0;
    first_seen = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    noteToken(8'h33);
    finishHandshake(20, lat);
    checkOutput("recapture_latency", 32'(lat), 32'd3);
    checkOutput("recapture_token_count", 32'(token_count), 32'd1);
    checkOutput("recapture_err", 32'(first_token_err), 32'(exp_err));
    drain();

    // Randomised traffic with a random consumer.
    doReset();
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(8'($urandom), lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    checkOutput("random_token_count", 32'(token_count), 32'(accepted[15:0]));
    checkOutput("random_err", 32'(first_token_err), 32'(exp_err));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/token_sync_receiver.md
Name: token_sync_receiver

Overview:
- Clocked receiving end of the four-phase bundled-data token channel driven by the asynchronous token buffers.
- Synchronises the incoming request, captures the data word and returns the acknowledge.
- Stores received tokens in a small FIFO and presents them on a synchronous valid/ready interface to clocked control logic.
- Checks that the first token after reset equals the ring's initial token value.

Parameters:
WIDTH, 8, token data width in bits
DEPTH, 4, FIFO entries; must be 2 or more
INIT_VALUE, 0, expected value of the first token received after reset
CHECK_INIT, 1, 1 enables the first-token check; 0 holds first_token_err at 0

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
in_req  input  1  four-phase request from the asynchronous sender; asynchronous to clk
in_data  input  WIDTH  bundled data; the sender holds it stable from in_req rise until in_ack rises
in_ack  output  1  four-phase acknowledge, driven directly from a flop
out_valid  output  1  FIFO non-empty
out_data  output  WIDTH  FIFO head entry; valid only while out_valid=1
out_ready  input  1  consumer accepts the head entry
fifo_count  output  $clog2(DEPTH+1)  current occupancy
token_count  output  16  tokens accepted since reset; wraps 0xFFFF->0
first_token_err  output  1  sticky; first token after reset differed from INIT_VALUE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - in_ack=0, out_valid=0, fifo_count=0, token_count=0, first_token_err=0.
  - FIFO pointers and both synchroniser flops cleared; state=IDLE; first-token flag armed.
- Synchroniser: in_req passes through two flops (req_m, then req_s). The FSM uses only req_s.
- FSM, two states:
  - IDLE: if req_s=1 and fifo_count<DEPTH, then in the same edge:
    - push in_data into the FIFO
    - in_ack<=1, token_count+=1
    - go to ACKED
  - IDLE: if req_s=1 and FIFO full, stay in IDLE with in_ack=0 (backpressure); the sender stalls.
  - ACKED: when req_s=0, in_ack<=0 and go to IDLE. While req_s=1, hold in_ack=1.
- Latency:
  - in_req rise to in_ack rise: 3 rising edges with FIFO space (2 synchroniser, 1 FSM).
  - in_req fall to in_ack fall: 3 edges.
  - Write to out_valid: out_valid rises the edge the push occurs; out_data is valid in the following cycle.
- One token per full handshake. A req_s level held high never produces a second push.
- FIFO:
  - Circular buffer with read/write pointers that wrap at DEPTH-1 to 0.
  - out_data = mem[rd_ptr], a combinational read.
  - Pop occurs when out_valid and out_ready are both 1 at the edge.
- Simultaneous push and pop:
  - Not full: both occur; fifo_count is unchanged.
  - Full: the push is refused that edge, because fullness is judged on pre-edge count. Only the pop occurs; the push happens on the next edge.
- out_ready with out_valid=0: ignored; no underflow.
- First-token check (CHECK_INIT=1):
  - On the first push after reset, compare in_data with INIT_VALUE[WIDTH-1:0].
  - Mismatch sets first_token_err=1 until reset.
  - Later tokens are not checked.
- Reset mid-handshake:
  - in_ack drops immediately and FIFO contents are lost.
  - If in_req is still high after reset release, the token is captured again after 3 edges.
  - The sender must be reset with this block.
- token_count increments on push only, never on pop.

Test Plan:
- Reset, then one handshake in_data=0x00 with INIT_VALUE=0 -> in_ack rises 3 edges after in_req; out_valid=1, out_data=0x00; token_count=1; first_token_err=0.
- First token 0x5A with INIT_VALUE=0 -> first_token_err=1 and stays 1 through later tokens 0x00 and 0x01; token_count=3.
- out_ready=0, 5 handshakes 0x10..0x14 with DEPTH=4 -> fifo_count=4; 5th handshake stalls with in_ack=0 while in_req=1. Then out_ready=1 for one cycle -> 0x10 popped, 0x14 accepted, in_ack rises.
- Continuous tokens 0x01..0x0A with out_ready=1 -> output order 0x01..0x0A; pointers wrap twice; fifo_count never exceeds 2; token_count=10.
- Assert rst_n while in_ack=1 and in_req=1 -> in_ack=0 immediately; fifo_count=0. After release with in_req still high, the token is re-captured 3 edges later and token_count=1.
- Pre-load token_count to 0xFFFF via 65535 handshakes, then one more -> token_count=0; no other outputs disturbed.
